// File: rtl/fabric2_arb_switch.sv
// N-master to 1-slave OCP switch with round-robin arbitration.
// Optional response timeout: define FABRIC2_ARB_TIMEOUT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif

module fabric2_arb_switch #(
  parameter int NPORTS     = 2,
  parameter int SEL_W      = 1,
  parameter int TMO_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [NPORTS*`ADDR_WIDTH-1:0]  i_M_MAddr,
  input  logic [NPORTS*3-1:0]            i_M_MCmd,
  input  logic [NPORTS*`DATA_WIDTH-1:0]  i_M_MData,
  input  logic [NPORTS*`BEN_WIDTH-1:0]   i_M_MByteEn,
  output logic [NPORTS-1:0]              o_M_SCmdAccept,
  output logic [NPORTS*`DATA_WIDTH-1:0]  o_M_SData,
  output logic [NPORTS*2-1:0]            o_M_SResp,
  output logic [`ADDR_WIDTH-1:0]         o_P_MAddr,
  output logic [2:0]                     o_P_MCmd,
  output logic [`DATA_WIDTH-1:0]         o_P_MData,
  output logic [`BEN_WIDTH-1:0]          o_P_MByteEn,
  input  logic                           i_P_SCmdAccept,
  input  logic [`DATA_WIDTH-1:0]         i_P_SData,
  input  logic [1:0]                     i_P_SResp,
  output logic                           o_busy,
  output logic [SEL_W-1:0]               o_grant
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int BW = `BEN_WIDTH;

  if (SEL_W < $clog2(NPORTS)) begin : g_sel_chk
    $error("SEL_W too narrow for NPORTS");
  end
  if (TMO_CYCLES >= 65536 || TMO_CYCLES < 1) begin : g_tmo_chk
    $error("TMO_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] last_q;
  logic             upd_last;
  logic [NPORTS-1:0] req;
  logic [SEL_W-1:0] winner;
  logic             found;
  logic [2:0]       gcmd;
  logic             tmo;
  int               g;

  assign g       = int'(grant_q);
  assign gcmd    = i_M_MCmd[g*3 +: 3];
  assign o_grant = grant_q;
  assign o_busy  = (state_q != ST_IDLE);

  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      req[k] = (i_M_MCmd[k*3 +: 3] != 3'd0);
    end
  end

  // Scan downward so the port closest after last wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = NPORTS; i >= 1; i--) begin
      int idx;
      idx = (int'(last_q) + i) % NPORTS;
      if (req[idx]) begin
        winner = SEL_W'(idx);
        found  = 1'b1;
      end
    end
  end

`ifdef FABRIC2_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;

  assign tmo = (cnt_q == 16'(TMO_CYCLES - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    upd_last = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_CMD;
          grant_d = winner;
        end
      end
      ST_CMD: begin
        if (gcmd == 3'd0) begin
          state_d = ST_IDLE;
        end else if (i_P_SCmdAccept) begin
          state_d  = ST_RESP;
          upd_last = 1'b1;
        end else if (tmo) begin
          state_d  = ST_IDLE;
          upd_last = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_P_SResp != 2'd0 || tmo) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_M_SCmdAccept = '0;
    o_M_SData      = '0;
    o_M_SResp      = '0;
    o_P_MAddr      = '0;
    o_P_MCmd       = 3'd0;
    o_P_MData      = '0;
    o_P_MByteEn    = '0;
    unique case (state_q)
      ST_CMD: begin
        o_P_MAddr         = i_M_MAddr[g*AW +: AW];
        o_P_MCmd          = gcmd;
        o_P_MData         = i_M_MData[g*DW +: DW];
        o_P_MByteEn       = i_M_MByteEn[g*BW +: BW];
        o_M_SCmdAccept[g] = i_P_SCmdAccept;
        if (tmo && !i_P_SCmdAccept && gcmd != 3'd0) begin
          o_M_SCmdAccept[g] = 1'b1;
          o_M_SResp[g*2 +: 2] = 2'd3;
        end
      end
      ST_RESP: begin
        o_M_SData[g*DW +: DW] = i_P_SData;
        o_M_SResp[g*2 +: 2]   = i_P_SResp;
        if (tmo && i_P_SResp == 2'd0) begin
          o_M_SResp[g*2 +: 2] = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= SEL_W'(NPORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (upd_last) begin
        last_q <= grant_q;
      end
    end
  end

endmodule

// File: doc/fabric2_arb_switch.md
Name: fabric2_arb_switch

Overview:
- Parametrised N-master to 1-slave OCP switch with a built-in round-robin arbiter.
- Generalises the fixed two-master, externally-selected slave switch: arbitration is internal, and each grant is held from command issue until the slave's response.
- Sits in fabric v2 in front of each shared slave port (memory, peripheral bridge); masters are CPU instruction/data ports and future DMA.

Parameters:
- NPORTS, 2, number of master ports (2..8).
- SEL_W, 1, grant index width; must be at least clog2(NPORTS).
- TMO_CYCLES, 255, response timeout in cycles; used only with FABRIC2_ARB_TIMEOUT_EN; must be less than 2^16.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- i_M_MAddr  in  NPORTS*`ADDR_WIDTH  master addresses; port k uses slice k.
- i_M_MCmd  in  NPORTS*3  master commands (IDLE=0, WR=1, RD=2).
- i_M_MData  in  NPORTS*`DATA_WIDTH  master write data.
- i_M_MByteEn  in  NPORTS*`BEN_WIDTH  master byte enables.
- o_M_SCmdAccept  out  NPORTS  per-master command accept.
- o_M_SData  out  NPORTS*`DATA_WIDTH  per-master read data.
- o_M_SResp  out  NPORTS*2  per-master response (NULL=0, DVA=1, ERR=3).
- o_P_MAddr, o_P_MCmd, o_P_MData, o_P_MByteEn  out  slave-side command (same widths as one master slice).
- i_P_SCmdAccept  in  1  slave command accept.
- i_P_SData  in  `DATA_WIDTH  slave read data.
- i_P_SResp  in  2  slave response.
- o_busy  out  1  high while not IDLE.
- o_grant  out  SEL_W  index of the current or last granted master.

Behaviour:
- Async reset (nrst=0), state on reset:
  - state=IDLE, o_grant=0, last-grant pointer=NPORTS-1, so port 0 has first priority.
  - All SCmdAccept=0, SData=0, SResp=NULL.
  - o_P_MCmd=IDLE, o_P_MAddr/MData/MByteEn=0, o_busy=0.
- Reset asserted mid-transaction aborts it immediately. No response is delivered.
- Slave transaction model: exactly one non-NULL SResp per accepted command, reads and writes alike.
- Request: port k requests when its MCmd != IDLE. A master holds its command stable until accepted.
- State IDLE:
  - Round-robin search from last+1, wrapping at NPORTS-1 to 0.
  - First requester found is registered into o_grant; go to CMD next cycle (1-cycle arbitration latency).
  - No requester: stay in IDLE.
  - Slave outputs stay IDLE/0 while in IDLE.
- State CMD:
  - Granted master's slice is driven combinationally to o_P_*.
  - o_M_SCmdAccept[grant]=i_P_SCmdAccept.
  - When i_P_SCmdAccept=1: go to RESP; the last-grant pointer becomes grant.
  - If the granted MCmd drops to IDLE before accept (protocol violation): return to IDLE without updating the pointer.
- State RESP:
  - o_P_MCmd=IDLE.
  - o_M_SData[grant]=i_P_SData and o_M_SResp[grant]=i_P_SResp, combinational.
  - When i_P_SResp != NULL: go to IDLE.
  - Minimum issue-to-issue spacing for back-to-back transactions is therefore 3 cycles plus slave latency.
- Non-granted masters always see SCmdAccept=0, SData=0, SResp=NULL.
- Simultaneous requests are resolved by round-robin only; no port can be granted twice in a row while another port is requesting.
- A new request arriving during CMD/RESP waits and is evaluated in the next IDLE cycle.
- o_busy=1 in CMD and RESP.

Optional Feature:
- Macro: FABRIC2_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to CMD and increments each cycle in CMD or RESP.
  - On reaching TMO_CYCLES without the expected accept/response, the block drives o_M_SResp[grant]=ERR (3) and o_M_SCmdAccept[grant]=1 (if in CMD) for one cycle, then returns to IDLE with the pointer updated.
  - Late slave responses after a timeout are ignored.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- Reset then single read: port 1 MCmd=RD, addr 0x100; slave accepts at once, DVA with data 0xCAFEBABE after 2 cycles -> port 1 receives SResp=1, SData=0xCAFEBABE; port 0 sees 0/NULL throughout; o_grant=1.
- Fairness, NPORTS=4: all ports request continuously (WR) -> grant order 0,1,2,3,0,1; no port is granted twice consecutively.
- Backpressure: i_P_SCmdAccept held 0 for 5 cycles -> o_P_MCmd stays at the granted command and o_M_SCmdAccept[grant]=0; on accept, state goes to RESP the next cycle.
- Reset mid-RESP: nrst pulsed low in RESP -> all outputs at reset values immediately; next arbitration starts at port 0.
- Protocol violation: granted master drops MCmd in CMD -> back to IDLE; pointer unchanged; the same port can win again.
- Timeout (macro defined, TMO_CYCLES=8): slave accepts but never responds -> granted master receives SResp=3 after 8 cycles; o_busy=0 the following cycle.
